// File: rtl/spi_bridge_pkg.sv
// Shared constants and helpers for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  // Frame-level state: waiting for select, receiving command, moving data.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CMD  = 2'd1;
  localparam state_t DATA = 2'd2;

  // Bus address step; 8-bit wrap from 0xFF to 0x00 is intended.
  function automatic logic [BYTE_W-1:0] addr_inc(input logic [BYTE_W-1:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulse detection.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  assign q_o = sync_q[STAGES-1];

  // Shift the pin through the chain, then compare against one extra flop.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_o <= sync_q[STAGES-1] & ~prev_q;
      fall_o <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning {rw,addr} + data-byte frames into byte-bus strobes.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              spi_clk_i,
  input  logic              spi_ncs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [BYTE_W-1:0] b_addr_o,
  input  logic [BYTE_W-1:0] b_data_i,
  output logic [BYTE_W-1:0] b_data_o,
  output logic              b_write_o,
  output logic              b_read_o
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk_i(clk_i), .nrst_i(nrst_i), .d_i(spi_clk_i),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
    .clk_i(clk_i), .nrst_i(nrst_i), .d_i(spi_ncs_i),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk_i(clk_i), .nrst_i(nrst_i), .d_i(spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // ncs and mosi only need the synchronised level.
  assign unused_edges = ^{sclk_s, ncs_rise, ncs_fall, mosi_rise, mosi_fall};

  state_t            state;
  logic [2:0]        bit_cnt;
  logic              rw;
  logic              ncs_d;
  logic              byte_vld_p0;
  logic              wr_p1, wr_p2;
  logic              rdc_p1;
  logic              rdd_p1, rdd_p2;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] tx_shift;

  // Frame FSM, bit counting and the strobe pipeline that follows each byte.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rw          <= 1'b0;
      ncs_d       <= 1'b0;
      byte_vld_p0 <= 1'b0;
      wr_p1       <= 1'b0;
      wr_p2       <= 1'b0;
      rdc_p1      <= 1'b0;
      rdd_p1      <= 1'b0;
      rdd_p2      <= 1'b0;
      spi_miso_o  <= 1'b0;
      b_addr_o    <= '0;
      b_data_o    <= '0;
      b_write_o   <= 1'b0;
      b_read_o    <= 1'b0;
    end else begin
      ncs_d       <= ncs_s;
      byte_vld_p0 <= 1'b0;
      wr_p1       <= 1'b0;
      rdc_p1      <= 1'b0;
      rdd_p1      <= 1'b0;
      // p1 -> p2: strobes and address steps; these survive ncs release
      wr_p2       <= wr_p1;
      rdd_p2      <= rdd_p1;
      b_write_o   <= wr_p1;
      b_read_o    <= rdc_p1 | rdd_p2;
      if (wr_p1)
        b_data_o <= rx_shift;
      if (AUTO_INC && (wr_p2 || rdd_p1))
        b_addr_o <= addr_inc(b_addr_o);

      if (ncs_s) begin
        state      <= IDLE;
        bit_cnt    <= 3'd0;
        spi_miso_o <= 1'b0;
      end else begin
        spi_miso_o <= (state == DATA && rw) ? tx_shift[BYTE_W-1] : 1'b0;
        case (state)
          IDLE: if (ncs_d) state <= CMD;
          CMD, DATA: begin
            // p0: a full byte is in rx_shift after the 8th rise
            if (sclk_rise) begin
              bit_cnt     <= bit_cnt + 3'd1;
              byte_vld_p0 <= (bit_cnt == 3'd7);
            end
          end
          default: state <= IDLE;
        endcase
        // p0 -> p1: decode the completed byte
        if (byte_vld_p0) begin
          if (state == CMD) begin
            rw       <= rx_shift[CMD_RW_BIT];
            b_addr_o <= {1'b0, rx_shift[CMD_ADDR_W-1:0]};
            rdc_p1   <= rx_shift[CMD_RW_BIT];
            state    <= DATA;
          end else if (state == DATA) begin
            rdd_p1 <= rw;
            wr_p1  <= ~rw;
          end
        end
      end
    end
  end

  // Shift registers: receive on rise, transmit on fall, reload on each read.
  always_ff @(posedge clk_i) begin
    if (!ncs_s && state != IDLE && sclk_rise)
      rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
    if (b_read_o)
      tx_shift <= b_data_i;
    else if (!ncs_s && state == DATA && sclk_fall && bit_cnt != 3'd0)
      tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench: two bridges (auto-increment on/off) behind one SPI bus.
module tb_spi_reg_bridge;

  localparam int SYNC = 2;
  localparam int HP   = 6;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ncs_a = 1'b1, ncs_b = 1'b1;
  logic       miso_a, miso_b;
  logic [7:0] addr_a, addr_b, wdat_a, wdat_b, rdat_a, rdat_b;
  logic       wr_a, wr_b, rd_a, rd_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int both_err = 0;

  logic [15:0] wq_a[$], wq_b[$];
  logic [7:0]  rq_a[$], rq_b[$];
  logic [7:0]  tx_buf[0:255];
  logic [7:0]  rx_buf[0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: each register reads back as its address inverted.
  assign rdat_a = addr_a ^ 8'hFF;
  assign rdat_b = addr_b ^ 8'hFF;

  spi_reg_bridge #(.SYNC_STAGES(SYNC), .AUTO_INC(1'b1)) dut (
    .clk_i(clk), .nrst_i(nrst), .spi_clk_i(sclk), .spi_ncs_i(ncs_a),
    .spi_mosi_i(mosi), .spi_miso_o(miso_a), .b_addr_o(addr_a),
    .b_data_i(rdat_a), .b_data_o(wdat_a), .b_write_o(wr_a), .b_read_o(rd_a)
  );

  spi_reg_bridge #(.SYNC_STAGES(SYNC), .AUTO_INC(1'b0)) dut_ni (
    .clk_i(clk), .nrst_i(nrst), .spi_clk_i(sclk), .spi_ncs_i(ncs_b),
    .spi_mosi_i(mosi), .spi_miso_o(miso_b), .b_addr_o(addr_b),
    .b_data_i(rdat_b), .b_data_o(wdat_b), .b_write_o(wr_b), .b_read_o(rd_b)
  );

  // Bus transaction log, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (wr_a) wq_a.push_back({addr_a, wdat_a});
      if (rd_a) rq_a.push_back(addr_a);
      if (wr_b) wq_b.push_back({addr_b, wdat_b});
      if (rd_b) rq_b.push_back(addr_b);
      if ((wr_a && rd_a) || (wr_b && rd_b)) both_err++;
    end
  end

  task automatic clear_logs();
    wq_a.delete(); rq_a.delete(); wq_b.delete(); rq_b.delete();
  endtask

  // One SPI frame on DUT sel (0/1); abort_bits>=0 truncates the last byte.
  task automatic do_frame(input int sel, input int nbytes, input int abort_bits);
    if (sel == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
    repeat (3*HP) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      int nb;
      logic [7:0] r;
      logic [7:0] t;
      nb = (abort_bits >= 0 && b == nbytes-1) ? abort_bits : 8;
      r = 8'h00;
      t = tx_buf[b];
      for (int i = 0; i < nb; i++) begin
        mosi = t[7-i];
        repeat (HP) @(negedge clk);
        sclk = 1'b1;
        last_rise_cyc = cyc + 1;
        r = {r[6:0], (sel == 0) ? miso_a : miso_b};
        repeat (HP) @(negedge clk);
        sclk = 1'b0;
      end
      rx_buf[b] = r;
    end
    repeat (HP) @(negedge clk);
    ncs_a = 1'b1; ncs_b = 1'b1;
    repeat (6*HP) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso_a); end
    checks++; if (addr_a !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", addr_a); end
    checks++; if (wdat_a !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", wdat_a); end
    checks++; if (wr_a !== 1'b0 || rd_a !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b want 00", wr_a, rd_a); end
    checks++; if (addr_b !== 8'h00 || wr_b !== 1'b0) begin errors++; $display("FAIL reset_ni got %h/%b want 00/0", addr_b, wr_b); end
    nrst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_single();
    int n;
    clear_logs();
    tx_buf[0] = 8'h05; tx_buf[1] = 8'hA5;
    fork
      do_frame(0, 2, -1);
      begin
        n = 0;
        while (wr_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 3000) begin errors++; $display("FAIL write_timeout got none want strobe"); end
        else begin
          if (addr_a !== 8'h05 || wdat_a !== 8'hA5) begin
            errors++; $display("FAIL write_single got %h/%h want 05/A5", addr_a, wdat_a);
          end
          checks++;
          if (cyc !== last_rise_cyc + SYNC + 3) begin
            errors++; $display("FAIL write_latency got %0d want %0d", cyc - last_rise_cyc, SYNC + 3);
          end
          @(negedge clk);
          checks++;
          if (wr_a !== 1'b0 || addr_a !== 8'h06) begin
            errors++; $display("FAIL write_after got %b/%h want 0/06", wr_a, addr_a);
          end
        end
      end
    join
    checks++; if (wq_a.size() !== 1) begin errors++; $display("FAIL write_count got %0d want 1", wq_a.size()); end
    checks++; if (rx_buf[1] !== 8'h00) begin errors++; $display("FAIL write_miso got %h want 00", rx_buf[1]); end
  endtask

  task automatic test_burst_write();
    logic [15:0] exp[3];
    clear_logs();
    tx_buf[0] = 8'h7E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    exp[0] = 16'h7E11; exp[1] = 16'h7F22; exp[2] = 16'h8033;
    do_frame(0, 4, -1);
    checks++; if (wq_a.size() !== 3) begin errors++; $display("FAIL burst_count got %0d want 3", wq_a.size()); end
    for (int i = 0; i < 3 && i < wq_a.size(); i++) begin
      checks++;
      if (wq_a[i] !== exp[i]) begin errors++; $display("FAIL burst_w%0d got %h want %h", i, wq_a[i], exp[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_buf[i] !== 8'h00) begin errors++; $display("FAIL burst_miso%0d got %h want 00", i, rx_buf[i]); end
    end
  endtask

  task automatic test_read();
    logic [7:0] expr[3];
    clear_logs();
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    expr[0] = 8'h03; expr[1] = 8'h04; expr[2] = 8'h05;
    do_frame(0, 3, -1);
    checks++; if (rx_buf[1] !== 8'hFC) begin errors++; $display("FAIL read_b0 got %h want FC", rx_buf[1]); end
    checks++; if (rx_buf[2] !== 8'hFB) begin errors++; $display("FAIL read_b1 got %h want FB", rx_buf[2]); end
    checks++; if (rq_a.size() !== 3) begin errors++; $display("FAIL read_count got %0d want 3", rq_a.size()); end
    for (int i = 0; i < 3 && i < rq_a.size(); i++) begin
      checks++;
      if (rq_a[i] !== expr[i]) begin errors++; $display("FAIL read_addr%0d got %h want %h", i, rq_a[i], expr[i]); end
    end
    checks++; if (wq_a.size() !== 0) begin errors++; $display("FAIL read_nowrite got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_abort();
    clear_logs();
    tx_buf[0] = 8'h20; tx_buf[1] = 8'($urandom);
    do_frame(0, 2, 5);
    checks++; if (wq_a.size() !== 0) begin errors++; $display("FAIL abort_nowrite got %0d want 0", wq_a.size()); end
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h5A;
    do_frame(0, 2, -1);
    checks++;
    if (wq_a.size() !== 1) begin errors++; $display("FAIL abort_next_count got %0d want 1", wq_a.size()); end
    else if (wq_a[0] !== 16'h105A) begin errors++; $display("FAIL abort_next got %h want 105A", wq_a[0]); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02; tx_buf[3] = 8'h03;
    fork
      do_frame(0, 4, -1);
      begin
        repeat (3*HP + 24*HP) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (addr_a !== 8'h00 || wdat_a !== 8'h00 || wr_a !== 1'b0 || rd_a !== 1'b0 || miso_a !== 1'b0) begin
          errors++; $display("FAIL midreset got %h/%h/%b%b%b want 00/00/000", addr_a, wdat_a, wr_a, rd_a, miso_a);
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        clear_logs();
      end
    join
    checks++;
    if (wq_a.size() + rq_a.size() !== 0) begin
      errors++; $display("FAIL midreset_quiet got %0d want 0", wq_a.size() + rq_a.size());
    end
    tx_buf[0] = 8'h41; tx_buf[1] = 8'h99;
    do_frame(0, 2, -1);
    checks++;
    if (wq_a.size() !== 1) begin errors++; $display("FAIL midreset_next_count got %0d want 1", wq_a.size()); end
    else if (wq_a[0] !== 16'h4199) begin errors++; $display("FAIL midreset_next got %h want 4199", wq_a[0]); end
  endtask

  task automatic test_no_autoinc();
    clear_logs();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02;
    do_frame(1, 3, -1);
    checks++;
    if (wq_b.size() !== 2) begin errors++; $display("FAIL noinc_count got %0d want 2", wq_b.size()); end
    else if (wq_b[0] !== 16'h0201 || wq_b[1] !== 16'h0202) begin
      errors++; $display("FAIL noinc got %h,%h want 0201,0202", wq_b[0], wq_b[1]);
    end
    checks++; if (addr_b !== 8'h02) begin errors++; $display("FAIL noinc_addr got %h want 02", addr_b); end
    checks++; if (wq_a.size() !== 0) begin errors++; $display("FAIL noinc_other got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_wrap();
    int nerr;
    logic [7:0] a;
    clear_logs();
    tx_buf[0] = 8'hFF;
    for (int i = 1; i <= 129; i++) tx_buf[i] = 8'h00;
    do_frame(0, 130, -1);
    nerr = 0;
    for (int i = 0; i < 129; i++) begin
      a = 8'(8'h7F + i);
      if (rx_buf[i+1] !== (a ^ 8'hFF)) nerr++;
    end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL wrap_miso got %0d bad bytes want 0", nerr); end
    checks++; if (rq_a.size() !== 130) begin errors++; $display("FAIL wrap_count got %0d want 130", rq_a.size()); end
    else begin
      checks++;
      if (rq_a[128] !== 8'hFF || rq_a[129] !== 8'h00) begin
        errors++; $display("FAIL wrap_addr got %h,%h want FF,00", rq_a[128], rq_a[129]);
      end
    end
    checks++; if (addr_a !== 8'h00) begin errors++; $display("FAIL wrap_final got %h want 00", addr_a); end
  endtask

  task automatic test_random();
    int rw, n, nerr;
    logic [7:0] base, a;
    for (int f = 0; f < 8; f++) begin
      clear_logs();
      rw   = $urandom_range(0, 1);
      base = 8'($urandom_range(0, 127));
      n    = $urandom_range(1, 4);
      tx_buf[0] = {rw[0], base[6:0]};
      for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
      do_frame(0, n + 1, -1);
      nerr = 0;
      if (rw == 1) begin
        if (wq_a.size() != 0 || rq_a.size() != n + 1) nerr++;
        else for (int i = 0; i <= n; i++) if (rq_a[i] !== 8'(base + i)) nerr++;
        for (int i = 0; i < n; i++) begin
          a = 8'(base + i);
          if (rx_buf[i+1] !== (a ^ 8'hFF)) nerr++;
        end
      end else begin
        if (rq_a.size() != 0 || wq_a.size() != n) nerr++;
        else for (int i = 0; i < n; i++) if (wq_a[i] !== {8'(base + i), tx_buf[i+1]}) nerr++;
        for (int i = 0; i <= n; i++) if (rx_buf[i] !== 8'h00) nerr++;
      end
      checks++;
      if (nerr !== 0) begin errors++; $display("FAIL rand_frame%0d rw=%0d got %0d diffs want 0", f, rw, nerr); end
      checks++;
      if (addr_a !== 8'(base + n)) begin errors++; $display("FAIL rand_addr%0d got %h want %h", f, addr_a, 8'(base + n)); end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_err !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", both_err); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_burst_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_no_autoinc();
    test_wrap();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
